branch_resolver: RTL and testbench

- Consumer of the CPU condition flags (CF, OF, NF, ZF) held in the flag register; resolves conditional jumps for the control sequencer.
- Accepts a jump request carrying a 4-bit condition code and an 8-bit target.
- Waits out any in-flight flag write, evaluates the condition against settled flags, then reports taken/not-taken and drives a PC load.
- Sits between the flag register outputs and the program counter load path.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/cond_eval.sv | 39 +++
 rtl/branch_resolver.sv | 102 ++++++++++
 tb/tb_branch_resolver.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition-code encoding and branch-resolver FSM states.
package cpu_pkg;

  localparam logic [3:0] COND_ALWAYS = 4'h0;
  localparam logic [3:0] COND_NEVER  = 4'h1;
  localparam logic [3:0] COND_EQ     = 4'h2;
  localparam logic [3:0] COND_NE     = 4'h3;
  localparam logic [3:0] COND_CS     = 4'h4;
  localparam logic [3:0] COND_CC     = 4'h5;
  localparam logic [3:0] COND_MI     = 4'h6;
  localparam logic [3:0] COND_PL     = 4'h7;
  localparam logic [3:0] COND_VS     = 4'h8;
  localparam logic [3:0] COND_VC     = 4'h9;
  localparam logic [3:0] COND_HI     = 4'hA;
  localparam logic [3:0] COND_LS     = 4'hB;
  localparam logic [3:0] COND_GE     = 4'hC;
  localparam logic [3:0] COND_LT     = 4'hD;
  localparam logic [3:0] COND_GT     = 4'hE;
  localparam logic [3:0] COND_LE     = 4'hF;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;

endpackage

// File: rtl/cond_eval.sv
// Combinational condition-code evaluator against the CF/OF/NF/ZF flags.
module cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] COND,
  input  logic       CF,
  input  logic       OF,
  input  logic       NF,
  input  logic       ZF,
  output logic       TRUE
);

  logic signed_lt;
  assign signed_lt = NF ^ OF;

  always_comb begin
    TRUE = 1'b0;
    case (COND)
      COND_ALWAYS: TRUE = 1'b1;
      COND_NEVER:  TRUE = 1'b0;
      COND_EQ:     TRUE = ZF;
      COND_NE:     TRUE = ~ZF;
      COND_CS:     TRUE = CF;
      COND_CC:     TRUE = ~CF;
      COND_MI:     TRUE = NF;
      COND_PL:     TRUE = ~NF;
      COND_VS:     TRUE = OF;
      COND_VC:     TRUE = ~OF;
      COND_HI:     TRUE = CF & ~ZF;
      COND_LS:     TRUE = ~CF | ZF;
      COND_GE:     TRUE = ~signed_lt;
      COND_LT:     TRUE = signed_lt;
      COND_GT:     TRUE = ~ZF & ~signed_lt;
      COND_LE:     TRUE = ZF | signed_lt;
      default:     TRUE = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Resolves conditional jumps: waits for pending flag writes, evaluates the
// condition on settled flags, then reports the result and pulses a PC load.
module branch_resolver
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int COND_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              REQ,
  input  logic [COND_W-1:0] COND,
  input  logic [ADDR_W-1:0] TARGET,
  input  logic              FWE,
  input  logic              CF,
  input  logic              OF,
  input  logic              NF,
  input  logic              ZF,
  output logic              BUSY,
  output logic              DONE,
  output logic              TAKEN,
  output logic              PC_LOAD,
  output logic [ADDR_W-1:0] PC_OUT
);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cond_q, cond_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              taken_q, taken_d;
  logic              done_q, done_d;
  logic              pc_load_q, pc_load_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              cond_true;

  cond_eval u_cond_eval (
    .COND (cond_q),
    .CF   (CF),
    .OF   (OF),
    .NF   (NF),
    .ZF   (ZF),
    .TRUE (cond_true)
  );

  always_comb begin
    state_d   = state_q;
    cond_d    = cond_q;
    target_d  = target_q;
    taken_d   = taken_q;
    done_d    = 1'b0;
    pc_load_d = 1'b0;
    pc_out_d  = pc_out_q;
    case (state_q)
      ST_WAIT: begin
        if (!FWE) state_d = ST_EVAL;
      end
      // Flags are stable here because FWE was low on the previous cycle.
      ST_EVAL: begin
        taken_d   = cond_true;
        done_d    = 1'b1;
        pc_load_d = cond_true;
        pc_out_d  = target_q;
        state_d   = ST_IDLE;
      end
      // IDLE and any unreachable encoding both accept a new request.
      default: begin
        state_d = ST_IDLE;
        if (REQ) begin
          cond_d   = COND[3:0];
          target_d = TARGET;
          state_d  = FWE ? ST_WAIT : ST_EVAL;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= ST_IDLE;
      cond_q    <= '0;
      target_q  <= '0;
      taken_q   <= 1'b0;
      done_q    <= 1'b0;
      pc_load_q <= 1'b0;
      pc_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond_d;
      target_q  <= target_d;
      taken_q   <= taken_d;
      done_q    <= done_d;
      pc_load_q <= pc_load_d;
      pc_out_q  <= pc_out_d;
    end
  end

  assign BUSY    = (state_q == ST_WAIT) || (state_q == ST_EVAL);
  assign DONE    = done_q;
  assign TAKEN   = taken_q;
  assign PC_LOAD = pc_load_q;
  assign PC_OUT  = pc_out_q;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ = 1'b0;
  logic [3:0] COND = '0;
  logic [7:0] TARGET = '0;
  logic       FWE = 1'b0;
  logic       CF = 1'b0, OF = 1'b0, NF = 1'b0, ZF = 1'b0;
  logic       BUSY, DONE, TAKEN, PC_LOAD;
  logic [7:0] PC_OUT;

  int n_asserts = 0;
  int n_fail = 0;

  branch_resolver #(.ADDR_W(8), .COND_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .COND(COND), .TARGET(TARGET),
    .FWE(FWE), .CF(CF), .OF(OF), .NF(NF), .ZF(ZF),
    .BUSY(BUSY), .DONE(DONE), .TAKEN(TAKEN), .PC_LOAD(PC_LOAD), .PC_OUT(PC_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_asserts++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Reference table for the condition encoding; f = {CF, OF, NF, ZF}.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic cf, of, nf, zf;
    cf = f[3]; of = f[2]; nf = f[1]; zf = f[0];
    case (c)
      4'h0: return 1'b1;
      4'h1: return 1'b0;
      4'h2: return zf;
      4'h3: return !zf;
      4'h4: return cf;
      4'h5: return !cf;
      4'h6: return nf;
      4'h7: return !nf;
      4'h8: return of;
      4'h9: return !of;
      4'hA: return cf && !zf;
      4'hB: return !cf || zf;
      4'hC: return nf == of;
      4'hD: return nf != of;
      4'hE: return !zf && (nf == of);
      default: return zf || (nf != of);
    endcase
  endfunction

  initial begin
    int sweep_bad;
    int done_bad;
    #2;
    chk("rst_busy", 8'(BUSY), 8'h0);
    chk("rst_done", 8'(DONE), 8'h0);
    chk("rst_taken", 8'(TAKEN), 8'h0);
    chk("rst_pcload", 8'(PC_LOAD), 8'h0);
    chk("rst_pcout", PC_OUT, 8'h00);
    tick();
    RESET = 1'b1;
    tick();

    // EQ without stall: REQ at cycle 0, result during cycle 2
    ZF = 1'b1; REQ = 1'b1; COND = 4'h2; TARGET = 8'h3C;
    tick();
    REQ = 1'b0; TARGET = 8'h00;
    chk("eq_c1_busy", 8'(BUSY), 8'h1);
    chk("eq_c1_done", 8'(DONE), 8'h0);
    tick();
    chk("eq_c2_done", 8'(DONE), 8'h1);
    chk("eq_c2_taken", 8'(TAKEN), 8'h1);
    chk("eq_c2_pcload", 8'(PC_LOAD), 8'h1);
    chk("eq_c2_pcout", PC_OUT, 8'h3C);
    chk("eq_c2_busy", 8'(BUSY), 8'h0);
    tick();
    chk("eq_c3_done", 8'(DONE), 8'h0);
    chk("eq_c3_pcload", 8'(PC_LOAD), 8'h0);
    chk("eq_c3_taken", 8'(TAKEN), 8'h1);
    chk("eq_c3_pcout", PC_OUT, 8'h3C);

    // Flag hazard: request under FWE, ZF becomes 1 at the next edge
    ZF = 1'b0; FWE = 1'b1; REQ = 1'b1; COND = 4'h2; TARGET = 8'hA5;
    tick();
    ZF = 1'b1; REQ = 1'b0;
    chk("haz_c1_busy", 8'(BUSY), 8'h1);
    tick();
    FWE = 1'b0;
    chk("haz_c2_busy", 8'(BUSY), 8'h1);
    chk("haz_c2_done", 8'(DONE), 8'h0);
    tick();
    chk("haz_c3_busy", 8'(BUSY), 8'h1);
    chk("haz_c3_done", 8'(DONE), 8'h0);
    tick();
    chk("haz_c4_done", 8'(DONE), 8'h1);
    chk("haz_c4_taken", 8'(TAKEN), 8'h1);
    chk("haz_c4_pcout", PC_OUT, 8'hA5);
    tick();

    // FWE during EVAL must not disturb the current result
    ZF = 1'b1; REQ = 1'b1; COND = 4'h2; TARGET = 8'h44;
    tick();
    REQ = 1'b0; FWE = 1'b1;
    tick();
    ZF = 1'b0; FWE = 1'b0;
    chk("evfwe_done", 8'(DONE), 8'h1);
    chk("evfwe_taken", 8'(TAKEN), 8'h1);
    tick();

    // Signed compares with NF=1, OF=0, ZF=0
    NF = 1'b1; OF = 1'b0; ZF = 1'b0; CF = 1'b0;
    REQ = 1'b1; COND = 4'hD; TARGET = 8'h55;
    tick();
    REQ = 1'b0;
    tick();
    chk("lt_done", 8'(DONE), 8'h1);
    chk("lt_taken", 8'(TAKEN), 8'h1);
    chk("lt_pcload", 8'(PC_LOAD), 8'h1);
    REQ = 1'b1; COND = 4'hC; TARGET = 8'h66;
    tick();
    REQ = 1'b0;
    tick();
    chk("ge_done", 8'(DONE), 8'h1);
    chk("ge_taken", 8'(TAKEN), 8'h0);
    chk("ge_pcload", 8'(PC_LOAD), 8'h0);
    chk("ge_pcout", PC_OUT, 8'h66);
    tick();

    // Back-to-back: REQ held high; targets offered during EVAL must be ignored
    REQ = 1'b1; COND = 4'h0; TARGET = 8'h10;
    tick();
    TARGET = 8'h99;
    chk("b2b_c1_done", 8'(DONE), 8'h0);
    tick();
    TARGET = 8'h20;
    chk("b2b_c2_done", 8'(DONE), 8'h1);
    chk("b2b_c2_pcout", PC_OUT, 8'h10);
    tick();
    TARGET = 8'h99;
    chk("b2b_c3_done", 8'(DONE), 8'h0);
    chk("b2b_c3_busy", 8'(BUSY), 8'h1);
    tick();
    TARGET = 8'h10;
    chk("b2b_c4_done", 8'(DONE), 8'h1);
    chk("b2b_c4_pcout", PC_OUT, 8'h20);
    tick();
    REQ = 1'b0;
    tick();
    chk("b2b_c6_done", 8'(DONE), 8'h1);
    chk("b2b_c6_pcout", PC_OUT, 8'h10);
    tick();
    chk("b2b_c7_busy", 8'(BUSY), 8'h0);

    // Reset in the middle of a stalled request
    FWE = 1'b1; REQ = 1'b1; COND = 4'h0; TARGET = 8'h77;
    tick();
    REQ = 1'b0;
    chk("mid_busy_pre", 8'(BUSY), 8'h1);
    #2;
    RESET = 1'b0;
    #1;
    chk("mid_busy", 8'(BUSY), 8'h0);
    chk("mid_done", 8'(DONE), 8'h0);
    chk("mid_taken", 8'(TAKEN), 8'h0);
    chk("mid_pcload", 8'(PC_LOAD), 8'h0);
    chk("mid_pcout", PC_OUT, 8'h00);
    tick();
    RESET = 1'b1; FWE = 1'b0;
    done_bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (DONE !== 1'b0 || BUSY !== 1'b0) done_bad++;
    end
    chk("post_rst_idle", 8'(done_bad), 8'h0);

    // Sweep every condition against every flag combination
    sweep_bad = 0;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic [3:0] fv;
        logic exp_t;
        fv = 4'(f);
        {CF, OF, NF, ZF} = fv;
        REQ = 1'b1; COND = 4'(c); TARGET = 8'(c * 16 + f);
        tick();
        REQ = 1'b0;
        tick();
        exp_t = ref_cond(4'(c), fv);
        if (DONE !== 1'b1 || TAKEN !== exp_t || PC_LOAD !== exp_t
            || PC_OUT !== 8'(c * 16 + f)) begin
          sweep_bad++;
          if (sweep_bad <= 4)
            chk($sformatf("sweep_c%0h_f%0h_taken", c, f), 8'(TAKEN), 8'(exp_t));
        end
      end
    end
    chk("sweep_errors", 8'(sweep_bad), 8'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
